operand_stage: RTL
==================

OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, setting the operand data width.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit, upstream offers an operand.
REQ-005 The block SHALL have port in_ready, output, 1 bit, the block can accept an operand.
REQ-006 The block SHALL have port in_data, input, WIDTH bits, operand value from the register-read path.
REQ-007 The block SHALL have port in_shift, input, 2 bits, shift code to travel with the operand (00 none, 01 left, 10 logical right, 11 arithmetic right).
REQ-008 The block SHALL have port flush, input, 1 bit, synchronous discard of all held operands.
REQ-009 The block SHALL have port out_valid, output, 1 bit, the head operand is presented to the shifter.
REQ-010 The block SHALL have port out_ready, input, 1 bit, the downstream shifter/ALU stage consumes the head.
REQ-011 The block SHALL have port out_data, output, WIDTH bits, head operand, driving the shifter data input.
REQ-012 The block SHALL have port out_shift, output, 2 bits, head shift code, driving the shifter shift select.
REQ-013 The block SHALL have port count, output, 2 bits, number of operands held (0..2).

Function
REQ-014 The block SHALL treat a transfer as accepted on an edge where in_valid and in_ready are both 1, and as consumed on an edge where out_valid and out_ready are both 1.
REQ-015 The block SHALL capture in_data and in_shift as one pair and present them unchanged; no arithmetic is applied to either field.
REQ-016 The block SHALL deliver operands strictly in acceptance order, with no loss and no duplication.
REQ-017 The block SHALL drive out_data and out_shift directly from registers, with no combinational path from in_* to out_*.
REQ-018 The block SHALL drive out_data and out_shift as don't-care-free zero when out_valid is 0.
REQ-019 The block SHALL make an accepted operand visible on out_* in the cycle after acceptance when the stage was empty, giving a latency of 1.
REQ-020 The block SHALL, on an edge with both accept and consume, keep count unchanged and present the next operand in order.
REQ-021 On an edge with flush=1, the block SHALL clear all held operands so that count=0 and out_valid=0, and SHALL discard any operand accepted or consumed on that edge.
REQ-022 The block SHALL give flush priority over every simultaneous handshake.
REQ-023 The block SHALL hold count equal to the number of valid entries at all times.

Reset
REQ-024 When rst_n=0, the block SHALL force out_valid=0, out_data=0, out_shift=00 and count=00 immediately, without waiting for clk.
REQ-025 When rst_n=0, the block SHALL force in_ready to its post-reset value (1) immediately.
REQ-026 The block SHALL discard any operand held when reset is asserted; after deassertion it SHALL accept input on the first clk edge.

Configuration
REQ-027 Macro OPERAND_STAGE_SKID_EN defined: the block SHALL provide two entries (head plus skid).
REQ-028 With OPERAND_STAGE_SKID_EN defined, the block SHALL drive in_ready from a register as NOT(skid entry valid), with no combinational dependence on out_ready.
REQ-029 With OPERAND_STAGE_SKID_EN defined, an accept while the head is stalled SHALL fill the skid entry, and the skid entry SHALL move to the head on the next consume.
REQ-030 With OPERAND_STAGE_SKID_EN defined, the block SHALL sustain one transfer per cycle under continuous flow.
REQ-031 Macro OPERAND_STAGE_SKID_EN undefined: the block SHALL provide a single entry, set in_ready = NOT out_valid OR out_ready (combinational), and limit count to at most 1.

Verification
REQ-032 Reset: assert rst_n=0 mid-stream with count=2 -> out_valid=0, count=0 and in_ready=1 immediately, before the next clk edge.
REQ-033 Latency: from empty, accept 16'h8001 with shift 11 -> next cycle out_valid=1, out_data=16'h8001, out_shift=11, count=1.
REQ-034 Stall (SKID_EN): hold out_ready=0 and send 16'h1234/01 then 16'hABCD/10 -> count=2 and in_ready=0; raise out_ready -> 1234/01 then ABCD/10 are delivered on consecutive cycles.
REQ-035 Throughput: in_valid=1 and out_ready=1 continuously for 8 operands 16'h0000..16'h0007 -> 8 consumes in 8 consecutive cycles with SKID_EN; identical order in both builds.
REQ-036 Flush: with count=2, pulse flush while in_valid=1 carrying 16'hFFFF -> next cycle count=0, out_valid=0, and 16'hFFFF never appears on out_data.
REQ-037 Simultaneous accept and consume at count=1 -> count stays 1 and out_data advances to the new operand.

Source files
------------

// File: rtl/operand_stage.sv
// rtl/operand_stage.sv - operand holding stage in front of the shifter/ALU
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake
//   in_data, in_shift     operand and its shift code (00 none, 01 left,
//                         10 logical right, 11 arithmetic right)
//   flush                 synchronous discard of all held operands
//   out_valid/out_ready   downstream handshake
//   out_data, out_shift   head operand, driven straight from registers
//   count                 number of operands held
//
// Build option: OPERAND_STAGE_SKID_EN
//   defined   - head plus skid entry, in_ready registered (= no skid held)
//   undefined - single entry, in_ready = !out_valid | out_ready

module operand_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_shift,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_shift,
    output logic [1:0]       count
);

    logic             head_vld_q, head_vld_d;
    logic [WIDTH-1:0] head_data_q, head_data_d;
    logic [1:0]       head_shift_q, head_shift_d;
    logic             acc;
    logic             cons;

    assign acc       = in_valid & in_ready;
    assign cons      = head_vld_q & out_ready;
    assign out_valid = head_vld_q;
    // Head registers are zeroed whenever the entry is empty, so outputs are
    // zero while out_valid is low without any output muxing.
    assign out_data  = head_data_q;
    assign out_shift = head_shift_q;

`ifdef OPERAND_STAGE_SKID_EN

    logic             skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [1:0]       skid_shift_q, skid_shift_d;

    // Ready only depends on the skid register, never on out_ready.
    assign in_ready = ~skid_vld_q;
    assign count    = {1'b0, head_vld_q} + {1'b0, skid_vld_q};

    always_comb begin
        head_vld_d   = head_vld_q;
        head_data_d  = head_data_q;
        head_shift_d = head_shift_q;
        skid_vld_d   = skid_vld_q;
        skid_data_d  = skid_data_q;
        skid_shift_d = skid_shift_q;
        if (flush) begin
            head_vld_d   = 1'b0;
            head_data_d  = '0;
            head_shift_d = 2'b00;
            skid_vld_d   = 1'b0;
            skid_data_d  = '0;
            skid_shift_d = 2'b00;
        end else if (cons) begin
            if (skid_vld_q) begin
                // Skid full implies in_ready low, so no accept can coincide.
                head_data_d  = skid_data_q;
                head_shift_d = skid_shift_q;
                skid_vld_d   = 1'b0;
                skid_data_d  = '0;
                skid_shift_d = 2'b00;
            end else if (acc) begin
                head_data_d  = in_data;
                head_shift_d = in_shift;
            end else begin
                head_vld_d   = 1'b0;
                head_data_d  = '0;
                head_shift_d = 2'b00;
            end
        end else if (acc) begin
            if (!head_vld_q) begin
                head_vld_d   = 1'b1;
                head_data_d  = in_data;
                head_shift_d = in_shift;
            end else begin
                skid_vld_d   = 1'b1;
                skid_data_d  = in_data;
                skid_shift_d = in_shift;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_vld_q   <= 1'b0;
            head_data_q  <= '0;
            head_shift_q <= 2'b00;
            skid_vld_q   <= 1'b0;
            skid_data_q  <= '0;
            skid_shift_q <= 2'b00;
        end else begin
            head_vld_q   <= head_vld_d;
            head_data_q  <= head_data_d;
            head_shift_q <= head_shift_d;
            skid_vld_q   <= skid_vld_d;
            skid_data_q  <= skid_data_d;
            skid_shift_q <= skid_shift_d;
        end
    end

`else

    // Single entry: a consume frees the slot in the same cycle.
    assign in_ready = ~head_vld_q | out_ready;
    assign count    = {1'b0, head_vld_q};

    always_comb begin
        head_vld_d   = head_vld_q;
        head_data_d  = head_data_q;
        head_shift_d = head_shift_q;
        if (flush) begin
            head_vld_d   = 1'b0;
            head_data_d  = '0;
            head_shift_d = 2'b00;
        end else if (acc) begin
            head_vld_d   = 1'b1;
            head_data_d  = in_data;
            head_shift_d = in_shift;
        end else if (cons) begin
            head_vld_d   = 1'b0;
            head_data_d  = '0;
            head_shift_d = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_vld_q   <= 1'b0;
            head_data_q  <= '0;
            head_shift_q <= 2'b00;
        end else begin
            head_vld_q   <= head_vld_d;
            head_data_q  <= head_data_d;
            head_shift_q <= head_shift_d;
        end
    end

`endif

endmodule
